adsb_modulator: RTL and testbench

ADSB_MODULATOR -- requirements
Module: adsb_modulator

---
 rtl/adsb_pkg.sv | 25 ++
 rtl/adsb_modulator_if.sv | 28 ++
 rtl/adsb_crc24_serial.sv | 33 +++
 rtl/adsb_modulator.sv | 196 +++++++++++++++++++
 tb/tb_adsb_modulator.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adsb_pkg.sv
// adsb_pkg -- shared constants and types for the ADS-B (Mode S extended
// squitter) PPM modulator.
//   PREAMBLE      : 16-chip preamble pattern, first chip in bit 15
//   CRC24_POLY    : Mode S generator without the implicit x^24 term
//   SHORT/LONG    : message lengths in bits
//   state_t       : modulator FSM states
package adsb_pkg;

  localparam logic [15:0] PREAMBLE   = 16'b1010000101000000;
  localparam logic [23:0] CRC24_POLY = 24'hFFF409;
  localparam int          SHORT_BITS = 56;
  localparam int          LONG_BITS  = 112;
  localparam int          PARITY_BITS = 24;
  localparam int          MSG_REG_W  = 128;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DISCARD,
    S_PREAMBLE,
    S_DATA,
    S_GAP
  } state_t;

endpackage

// File: rtl/adsb_modulator_if.sv
// adsb_modulator_if -- groups the message stream and DAC sample bus of the
// modulator.
//   master : message source / sample sink (drives the S_axis_* inputs)
//   slave  : the modulator side
interface adsb_modulator_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int IQ_WIDTH       = 16
);
  logic                      S_axis_valid;
  logic                      S_axis_ready;
  logic [AXI_DATA_WIDTH-1:0] S_axis_data;
  logic                      S_axis_last;
  logic                      Dac_valid;
  logic [IQ_WIDTH-1:0]       Dac_data_i;
  logic [IQ_WIDTH-1:0]       Dac_data_q;
  logic                      Busy;
  logic                      Frame_error;

  modport master (
    output S_axis_valid, S_axis_data, S_axis_last,
    input  S_axis_ready, Dac_valid, Dac_data_i, Dac_data_q, Busy, Frame_error
  );

  modport slave (
    input  S_axis_valid, S_axis_data, S_axis_last,
    output S_axis_ready, Dac_valid, Dac_data_i, Dac_data_q, Busy, Frame_error
  );
endinterface

// File: rtl/adsb_crc24_serial.sv
// adsb_crc24_serial -- bit-serial Mode S CRC-24.
//   clk, rst     : clock, synchronous active-high reset
//   i_init       : clear the remainder before a new message
//   i_shift_in   : fold i_bit into the remainder (message bits)
//   i_bit        : message bit, MSB first
//   i_shift_out  : shift the remainder left so o_msb walks the parity out
//   o_msb        : current parity bit (remainder MSB)
module adsb_crc24_serial
  import adsb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_init,
  input  logic i_shift_in,
  input  logic i_bit,
  input  logic i_shift_out,
  output logic o_msb
);
  logic [23:0] r_crc;
  logic        w_fb;

  assign w_fb  = i_bit ^ r_crc[23];
  assign o_msb = r_crc[23];

  always_ff @(posedge clk) begin
    if (rst || i_init)
      r_crc <= '0;
    else if (i_shift_in)
      r_crc <= {r_crc[22:0], 1'b0} ^ (w_fb ? CRC24_POLY : 24'h0);
    else if (i_shift_out)
      r_crc <= {r_crc[22:0], 1'b0};
  end
endmodule

// File: rtl/adsb_modulator.sv
// adsb_modulator -- accepts a 56/112-bit Mode S message as 32-bit beats and
// emits it as a PPM envelope on the I channel: 16-chip preamble, two chips
// per data bit (1 -> high,low; 0 -> low,high), then GAP_CHIPS zero chips.
// Each chip is SAMPLES_PER_CHIP Dac_valid strobes spaced CLKS_PER_SAMPLE clocks.
//   Data_clk/Data_rst          : clock, synchronous active-high reset
//   S_axis_valid/ready/data/last : message beats, MSB first
//   Dac_valid/Dac_data_i/q     : sample strobe and I/Q (Q always 0)
//   Busy                       : frame being loaded or transmitted
//   Frame_error                : one-cycle pulse when a message is dropped
// Build option: define ADSB_MODULATOR_CRC_EN to replace the supplied parity
// with a CRC-24 computed over the transmitted message bits.
module adsb_modulator
  import adsb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int IQ_WIDTH         = 16,
  parameter int SAMPLES_PER_CHIP = 2,
  parameter int CLKS_PER_SAMPLE  = 4,
  parameter int GAP_CHIPS        = 8,
  parameter int AMPLITUDE        = 2**(IQ_WIDTH-2)
) (
  input  logic                      Data_clk,
  input  logic                      Data_rst,
  input  logic                      S_axis_valid,
  output logic                      S_axis_ready,
  input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic                      S_axis_last,
  output logic                      Dac_valid,
  output logic [IQ_WIDTH-1:0]       Dac_data_i,
  output logic [IQ_WIDTH-1:0]       Dac_data_q,
  output logic                      Busy,
  output logic                      Frame_error
);
  localparam int CLK_W = $clog2(CLKS_PER_SAMPLE + 1);
  localparam int SMP_W = $clog2(SAMPLES_PER_CHIP + 1);
  localparam int CHP_W = $clog2(GAP_CHIPS + 17);

  state_t                 r_state, w_next;
  logic [2:0]             r_beat;      // beats accepted in this message
  logic [MSG_REG_W-1:0]   r_msg;
  logic                   r_long;
  logic [CLK_W-1:0]       r_clk_cnt;
  logic [SMP_W-1:0]       r_smp;
  logic [CHP_W-1:0]       r_chip;      // preamble chip, then gap chip
  logic                   r_half;      // second chip of a data bit
  logic [6:0]             r_bit;
  logic                   r_err;

  logic       w_ready, w_fire, w_tx, w_strobe, w_chip_end, w_bit_end;
  logic       w_last_bit, w_start, w_err_set, w_msg_bit, w_data_bit, w_chip_hi;
  logic [2:0] w_beat_num;

  assign w_ready    = (r_state == S_IDLE) || (r_state == S_LOAD) ||
                      (r_state == S_DISCARD);
  assign w_fire     = S_axis_valid && w_ready && !Data_rst;
  assign w_beat_num = r_beat + 3'd1;
  assign w_tx       = (r_state == S_PREAMBLE) || (r_state == S_DATA) ||
                      (r_state == S_GAP);
  // Sample slot opens on the first cycle of the preamble, since the counter
  // is cleared on entry.
  assign w_strobe   = w_tx && (r_clk_cnt == '0);
  assign w_chip_end = w_strobe && (r_smp == SMP_W'(SAMPLES_PER_CHIP - 1));
  assign w_bit_end  = (r_state == S_DATA) && w_chip_end && r_half;
  assign w_last_bit = r_bit == (r_long ? 7'(LONG_BITS - 1) : 7'(SHORT_BITS - 1));
  assign w_msg_bit  = r_msg[7'd127 - r_bit];

`ifdef ADSB_MODULATOR_CRC_EN
  logic w_parity, w_crc_msb;
  assign w_parity = r_bit >= (r_long ? 7'(LONG_BITS - PARITY_BITS)
                                     : 7'(SHORT_BITS - PARITY_BITS));
  assign w_data_bit = w_parity ? w_crc_msb : w_msg_bit;

  adsb_crc24_serial u_crc (
    .clk         (Data_clk),
    .rst         (Data_rst),
    .i_init      (w_start),
    .i_shift_in  (w_bit_end && !w_parity),
    .i_bit       (w_msg_bit),
    .i_shift_out (w_bit_end && w_parity),
    .o_msb       (w_crc_msb)
  );
`else
  assign w_data_bit = w_msg_bit;
`endif

  always_comb begin
    w_chip_hi = 1'b0;
    case (r_state)
      S_PREAMBLE: w_chip_hi = PREAMBLE[4'd15 - r_chip[3:0]];
      S_DATA:     w_chip_hi = w_data_bit ^ r_half;
      default:    w_chip_hi = 1'b0;
    endcase
  end

  // Next state
  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    w_start   = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_fire) begin
          if (S_axis_last) w_err_set = 1'b1;
          else             w_next    = S_LOAD;
        end
      S_LOAD:
        if (w_fire) begin
          case (w_beat_num)
            3'd2: if (S_axis_last) begin w_next = S_PREAMBLE; w_start = 1'b1; end
            3'd3: if (S_axis_last) begin w_next = S_IDLE; w_err_set = 1'b1; end
            3'd4: begin
              if (S_axis_last) begin w_next = S_PREAMBLE; w_start = 1'b1; end
              else                   w_next = S_DISCARD;
            end
            default: ;
          endcase
        end
      S_DISCARD:
        if (w_fire && S_axis_last) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      S_PREAMBLE:
        if (w_chip_end && r_chip == CHP_W'(15)) w_next = S_DATA;
      S_DATA:
        if (w_bit_end && w_last_bit) w_next = (GAP_CHIPS == 0) ? S_IDLE : S_GAP;
      S_GAP:
        if (w_chip_end && r_chip == CHP_W'(GAP_CHIPS - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Data_clk) begin
    if (Data_rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_msg     <= '0;
      r_long    <= 1'b0;
      r_clk_cnt <= '0;
      r_smp     <= '0;
      r_chip    <= '0;
      r_half    <= 1'b0;
      r_bit     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_set;

      if (w_fire && !r_beat[2]) begin
        case (r_beat[1:0])
          2'd0: r_msg[127:96] <= S_axis_data[31:0];
          2'd1: r_msg[95:64]  <= S_axis_data[31:0];
          2'd2: r_msg[63:32]  <= S_axis_data[31:0];
          2'd3: r_msg[31:0]   <= S_axis_data[31:0];
        endcase
      end
      if (w_next == S_IDLE || w_start)
        r_beat <= '0;
      else if (w_fire && !r_beat[2])
        r_beat <= w_beat_num;

      if (w_start) begin
        r_long    <= (w_beat_num == 3'd4);
        r_clk_cnt <= '0;
        r_smp     <= '0;
        r_chip    <= '0;
        r_half    <= 1'b0;
        r_bit     <= '0;
      end else if (w_tx) begin
        r_clk_cnt <= (r_clk_cnt == CLK_W'(CLKS_PER_SAMPLE - 1)) ? '0 : r_clk_cnt + 1'b1;
        if (w_strobe)
          r_smp <= (r_smp == SMP_W'(SAMPLES_PER_CHIP - 1)) ? '0 : r_smp + 1'b1;
        if (w_chip_end) begin
          case (r_state)
            // Preamble counter wraps to 0 so the gap count starts clean.
            S_PREAMBLE: r_chip <= (r_chip == CHP_W'(15)) ? '0 : r_chip + 1'b1;
            S_DATA: begin
              r_half <= ~r_half;
              if (r_half) r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
            end
            S_GAP:   r_chip <= r_chip + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign S_axis_ready = w_ready && !Data_rst;
  assign Busy         = (r_state != S_IDLE) && !Data_rst;
  assign Frame_error  = r_err && !Data_rst;
  assign Dac_valid    = w_strobe && !Data_rst;
  assign Dac_data_i   = (Dac_valid && w_chip_hi) ? IQ_WIDTH'(AMPLITUDE) : '0;
  assign Dac_data_q   = '0;

endmodule

// File: tb/tb_adsb_modulator.sv
// tb_adsb_modulator -- directed + randomized bench for adsb_modulator.
// Expected sample streams come from a chip-level model of the ADS-B frame
// (preamble list, Manchester bit pairs, gap) with the CRC computed by
// polynomial long division.
module tb_adsb_modulator;
  localparam int IQW = 16, SPC = 2, CPS = 4, GAP = 8;
  localparam int AMP = 2**(IQW-2);

  logic Data_clk = 1'b0;
  logic Data_rst = 1'b1;
  always #5 Data_clk = ~Data_clk;

  adsb_modulator_if #(.AXI_DATA_WIDTH(32), .IQ_WIDTH(IQW)) bus();

  adsb_modulator #(
    .AXI_DATA_WIDTH(32), .IQ_WIDTH(IQW), .SAMPLES_PER_CHIP(SPC),
    .CLKS_PER_SAMPLE(CPS), .GAP_CHIPS(GAP), .AMPLITUDE(AMP)
  ) dut (
    .Data_clk     (Data_clk),
    .Data_rst     (Data_rst),
    .S_axis_valid (bus.S_axis_valid),
    .S_axis_ready (bus.S_axis_ready),
    .S_axis_data  (bus.S_axis_data),
    .S_axis_last  (bus.S_axis_last),
    .Dac_valid    (bus.Dac_valid),
    .Dac_data_i   (bus.Dac_data_i),
    .Dac_data_q   (bus.Dac_data_q),
    .Busy         (bus.Busy),
    .Frame_error  (bus.Frame_error)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: sole writer of everything below.
  int cyc = 0;
  int cap[$];
  int tcap[$];
  int bad_q = 0, bad_idle = 0, busy_lo = 0, err_cnt = 0, acc_cnt = 0, last_cyc = 0;

  always @(posedge Data_clk) cyc <= cyc + 1;

  always @(negedge Data_clk) begin
    if (bus.Dac_valid) begin
      cap.push_back(int'(bus.Dac_data_i));
      tcap.push_back(cyc);
      if (bus.Dac_data_q !== '0) bad_q <= bad_q + 1;
      if (!bus.Busy) busy_lo <= busy_lo + 1;
    end else if (bus.Dac_data_i !== '0 || bus.Dac_data_q !== '0) begin
      bad_idle <= bad_idle + 1;
    end
    if (bus.Frame_error) err_cnt <= err_cnt + 1;
    if (bus.S_axis_valid && bus.S_axis_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (bus.S_axis_last) last_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge Data_clk); #1; end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] model_crc(input logic [127:0] msg, input int n);
    bit a[112];
    logic [24:0] g;
    logic [23:0] r;
    g = 25'h1FFF409;
    for (int i = 0; i < 112; i++) a[i] = (i < n - 24) ? msg[127-i] : 1'b0;
    for (int i = 0; i <= n - 25; i++)
      if (a[i]) for (int j = 0; j < 25; j++) a[i+j] = a[i+j] ^ g[24-j];
    for (int k = 0; k < 24; k++) r[23-k] = a[n-24+k];
    return r;
  endfunction

  int exp_q[$];

  function automatic void build_exp(input logic [127:0] msg, input int n);
    logic [15:0] pre;
    logic [23:0] crc;
    bit chips[$];
    bit b;
    pre = 16'b1010000101000000;
    crc = model_crc(msg, n);
    exp_q.delete();
    for (int c = 0; c < 16; c++) chips.push_back(pre[15-c]);
    for (int i = 0; i < n; i++) begin
      b = msg[127-i];
`ifdef ADSB_MODULATOR_CRC_EN
      if (i >= n - 24) b = crc[23-(i-(n-24))];
`endif
      chips.push_back(b);
      chips.push_back(!b);
    end
    for (int c = 0; c < GAP; c++) chips.push_back(1'b0);
    foreach (chips[c]) repeat (SPC) exp_q.push_back(chips[c] ? AMP : 0);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [191:0] b, input int n, input bit gaps);
    int g;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        bus.S_axis_valid = 1'b0;
        step($urandom_range(0, 3));
      end
      bus.S_axis_valid = 1'b1;
      bus.S_axis_data  = b[191-32*k -: 32];
      bus.S_axis_last  = (k == n - 1);
      g = 0;
      while (!bus.S_axis_ready && g < 100) begin step(1); g++; end
      chk("ready_timeout", (g < 100) ? 1 : 0, 1);
      step(1);
      bus.S_axis_valid = 1'b0;
      bus.S_axis_last  = 1'b0;
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (bus.Busy && g < 4000) begin step(1); g++; end
    chk("frame_timeout", (g < 4000) ? 1 : 0, 1);
    step(3);
  endtask

  // Compare the captured frame starting at cap[base] with the model and decode it.
  task automatic check_frame(input string tag, input logic [127:0] msg, input int n,
                             input int base, output logic [127:0] dec);
    int cnt, mis, bad_t;
    logic [15:0] pre;
    build_exp(msg, n);
    cnt = cap.size() - base;
    chk({tag, "_strobes"}, cnt, (16 + 2*n + GAP) * SPC);
    mis = 0;
    for (int i = 0; i < exp_q.size() && i < cnt; i++)
      if (cap[base+i] != exp_q[i]) mis++;
    chk({tag, "_sample_mismatch"}, mis, 0);
    if (cnt > 0) chk({tag, "_first_strobe_cycle"}, tcap[base], last_cyc + 1);
    bad_t = 0;
    for (int i = 1; i < cnt; i++)
      if (tcap[base+i] - tcap[base+i-1] != CPS) bad_t++;
    chk({tag, "_strobe_spacing"}, bad_t, 0);
    pre = '0;
    dec = '0;
    for (int c = 0; c < 16; c++)
      if (base + c*SPC < cap.size()) pre[15-c] = (cap[base + c*SPC] != 0);
    chk({tag, "_preamble"}, pre, 16'b1010000101000000);
    for (int i = 0; i < n; i++)
      if (base + (16 + 2*i)*SPC < cap.size())
        dec[127-i] = (cap[base + (16 + 2*i)*SPC] != 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] msg, dec;
    logic [191:0] beats;
    int base, e0, a0, g, n0;

    bus.S_axis_valid = 1'b0;
    bus.S_axis_data  = '0;
    bus.S_axis_last  = 1'b0;
    Data_rst = 1'b1;
    step(3);
    bus.S_axis_valid = 1'b1;
    #1;
    chk("rst_ready", bus.S_axis_ready, 0);
    chk("rst_dac_valid", bus.Dac_valid, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_frame_error", bus.Frame_error, 0);
    chk("rst_dac_i", bus.Dac_data_i, 0);
    chk("rst_dac_q", bus.Dac_data_q, 0);
    bus.S_axis_valid = 1'b0;
    step(1);
    Data_rst = 1'b0;
    step(1);
    chk("idle_ready", bus.S_axis_ready, 1);
    chk("idle_busy", bus.Busy, 0);

    // Known 112-bit squitter.
    msg = {112'h8D4840D6202CC371C32CE0576098, 16'h0};
    beats = {msg, 64'h0};
    base = cap.size();
    send(beats, 4, 1'b0);
    wait_done();
    check_frame("known112", msg, 112, base, dec);
    chk("known112_dec_hi", dec[127:64], msg[127:64]);
    chk("known112_dec_lo", dec[63:16], msg[63:16]);

    // Same message with parity zeroed.
    msg = {112'h8D4840D6202CC371C32CE0000000, 16'h0};
    beats = {msg, 64'h0};
    base = cap.size();
    send(beats, 4, 1'b0);
    wait_done();
    check_frame("zeroparity", msg, 112, base, dec);
`ifdef ADSB_MODULATOR_CRC_EN
    chk("zeroparity_crc", dec[39:16], 24'h576098);
`else
    chk("zeroparity_raw", dec[39:16], 24'h0);
`endif

    // Random 56-bit short frame; low byte of beat 2 is ignored.
    msg = {$urandom(), $urandom(), 64'h0};
    beats = {msg, 64'h0};
    msg[71:0] = '0;
    base = cap.size();
    n0 = busy_lo;
    send(beats, 2, 1'b0);
    wait_done();
    check_frame("short56", msg, 56, base, dec);
    chk("short56_dec", dec[127:72], msg[127:72]);
    chk("short56_busy_during", busy_lo - n0, 0);
    chk("short56_busy_after", bus.Busy, 0);

    // Last on beat 3: dropped.
    e0 = err_cnt; base = cap.size();
    send({$urandom(), $urandom(), $urandom(), 96'h0}, 3, 1'b0);
    chk("drop3_ready_next", bus.S_axis_ready, 1);
    step(5);
    chk("drop3_err_pulses", err_cnt - e0, 1);
    chk("drop3_no_samples", cap.size() - base, 0);

    // Last on beat 1: dropped.
    e0 = err_cnt; base = cap.size();
    send({$urandom(), 160'h0}, 1, 1'b1);
    step(5);
    chk("drop1_err_pulses", err_cnt - e0, 1);
    chk("drop1_no_samples", cap.size() - base, 0);

    // Overlong message: discarded.
    e0 = err_cnt; a0 = acc_cnt; base = cap.size();
    send({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 6, 1'b1);
    chk("long6_ready_next", bus.S_axis_ready, 1);
    step(5);
    chk("long6_accepted", acc_cnt - a0, 6);
    chk("long6_err_pulses", err_cnt - e0, 1);
    chk("long6_no_samples", cap.size() - base, 0);

    // Reset in the middle of a frame.
    e0 = err_cnt;
    base = cap.size();
    send({$urandom(), $urandom(), $urandom(), $urandom(), 64'h0}, 4, 1'b1);
    g = 0;
    while (cap.size() - base < 100 && g < 1000) begin step(1); g++; end
    chk("midrst_reach100", cap.size() - base, 100);
    Data_rst = 1'b1;
    #1;
    chk("midrst_dac_valid", bus.Dac_valid, 0);
    chk("midrst_busy", bus.Busy, 0);
    step(2);
    Data_rst = 1'b0;
    n0 = cap.size();
    step(60);
    chk("midrst_no_more_samples", cap.size() - n0, 0);
    chk("midrst_busy_after", bus.Busy, 0);
    chk("midrst_no_err", err_cnt - e0, 0);

    msg = {$urandom(), $urandom(), 64'h0};
    beats = {msg, 64'h0};
    msg[71:0] = '0;
    base = cap.size();
    send(beats, 2, 1'b1);
    wait_done();
    check_frame("postrst56", msg, 56, base, dec);
    chk("postrst56_dec", dec[127:72], msg[127:72]);

    // Random long frames with random valid gaps.
    for (int r = 0; r < 2; r++) begin
      msg = {$urandom(), $urandom(), $urandom(), $urandom()};
      beats = {msg, 64'h0};
      msg[15:0] = '0;
      base = cap.size();
      send(beats, 4, 1'b1);
      wait_done();
      check_frame("rand112", msg, 112, base, dec);
`ifndef ADSB_MODULATOR_CRC_EN
      chk("rand112_dec_lo", dec[63:16], msg[63:16]);
`endif
      chk("rand112_dec_hi", dec[127:64], msg[127:64]);
    end

    chk("q_nonzero", bad_q, 0);
    chk("idle_nonzero", bad_idle, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
